// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor built only from gate primitives: d = x^y^c,
// bo = (~x & y) | (~(x^y) & c).
module full_sub (
    input  logic      x,
    input  logic      y,
    input  logic      c,
    output wire logic d,
    output wire logic bo
);

    wire xy_s;
    wire nx_s;
    wire nxy_s;
    wire t0_s;
    wire t1_s;

    xor g_xy  (xy_s, x, y);
    xor g_d   (d, xy_s, c);
    not g_nx  (nx_s, x);
    and g_t0  (t0_s, nx_s, y);
    not g_nxy (nxy_s, xy_s);
    and g_t1  (t1_s, nxy_s, c);
    or  g_bo  (bo, t0_s, t1_s);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin computed LSB first through one full_sub
// cell, with valid/ready handshakes on operands and result.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   diff_r;
    logic [WIDTH-1:0]   diff_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               borrow_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               d_s;
    logic               bo_s;

    full_sub u_full_sub (
        .x  (a_sh_r[0]),
        .y  (b_sh_r[0]),
        .c  (borrow_r),
        .d  (d_s),
        .bo (bo_s)
    );

    // Next diff value: shift right, new bit enters at the MSB (works for WIDTH=1).
    always_comb begin
        diff_nx_s            = diff_r >> 1;
        diff_nx_s[WIDTH-1]   = d_s;
    end

    // Controller, operand/result shift registers, bit counter and borrow flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            borrow_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (in_valid && in_ready_r) begin
                        a_sh_r     <= a;
                        b_sh_r     <= b;
                        borrow_r   <= bin;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    diff_r   <= diff_nx_s;
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    borrow_r <= bo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    // Unused encoding recovers as IDLE.
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = borrow_r;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH = 8, 1 and 64.
module tb_serial_sub;

    logic        clk;
    logic        rst_n;
    logic [63:0] ta;
    logic [63:0] tbv;
    logic        tbin;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  bo;
    logic [7:0]  d8;
    logic [0:0]  d1;
    logic [63:0] d64;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        int         hold;
    } vec_t;

    vec_t vt[9];

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ta[7:0]), .b(tbv[7:0]), .bin(tbin), .out_valid(ov[0]),
        .out_ready(ordy[0]), .diff(d8), .bout(bo[0])
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ta[0:0]), .b(tbv[0:0]), .bin(tbin), .out_valid(ov[1]),
        .out_ready(ordy[1]), .diff(d1), .bout(bo[1])
    );

    serial_sub #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(ta), .b(tbv), .bin(tbin), .out_valid(ov[2]),
        .out_ready(ordy[2]), .diff(d64), .bout(bo[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dsel(input int s);
        case (s)
            0:       return {56'd0, d8};
            1:       return {63'd0, d1};
            default: return d64;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input int s, input logic [63:0] av, input logic [63:0] bv,
                         input logic bi, input int hold, input logic [63:0] ed,
                         input logic eb, input int lat, input string nm);
        int cyc;
        cyc = 0;
        while (!ir[s] && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk({nm, " in_ready"}, 64'(ir[s]), 64'd1);
        ta = av; tbv = bv; tbin = bi; iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        cyc = 0;
        while (!ov[s] && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " diff"}, dsel(s), ed);
        chk({nm, " bout"}, 64'(bo[s]), 64'(eb));
        // Stall the result; a fresh operand offered meanwhile must be ignored.
        for (int k = 0; k < hold; k++) begin
            ta = ~av; tbv = av; iv[s] = 1'b1;
            @(posedge clk); #1;
            chk({nm, " hold out_valid"}, 64'(ov[s]), 64'd1);
            chk({nm, " hold diff"}, dsel(s), ed);
            chk({nm, " hold in_ready"}, 64'(ir[s]), 64'd0);
        end
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
        chk({nm, " post out_valid"}, 64'(ov[s]), 64'd0);
        chk({nm, " post in_ready"}, 64'(ir[s]), 64'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [8:0] rexp;

        n_vec = 0; n_err = 0;
        ta = 64'd0; tbv = 64'd0; tbin = 1'b0; iv = 3'b000; ordy = 3'b000;

        vt[0] = '{8'h3C, 8'h1A, 1'b0, 8'h22, 1'b0, 0};
        vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1};
        vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0};
        vt[3] = '{8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 5};
        vt[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 2};
        vt[6] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 0};
        vt[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1};
        vt[8] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 0};

        rst_n = 1'b0;
        #12;
        chk("reset in_ready", 64'(ir[0]), 64'd1);
        chk("reset out_valid", 64'(ov[0]), 64'd0);
        chk("reset diff", 64'(d8), 64'd0);
        chk("reset bout", 64'(bo[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op(0, 64'(vt[i].a), 64'(vt[i].b), vt[i].bin, vt[i].hold,
                  64'(vt[i].d), vt[i].bo, 8, $sformatf("w8 vec%0d", i));

        // Abort an operation three RUN cycles in with an asynchronous reset.
        @(posedge clk); #1;
        ta = 64'h55; tbv = 64'h0F; tbin = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 64'(ir[0]), 64'd1);
        chk("midrst out_valid", 64'(ov[0]), 64'd0);
        chk("midrst diff", 64'(d8), 64'd0);
        chk("midrst bout", 64'(bo[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 64'h10, 64'h01, 1'b0, 0, 64'h0F, 1'b0, 8, "after reset");

        do_op(1, 64'd0, 64'd1, 1'b1, 0, 64'd0, 1'b1, 1, "w1 0-1-1");
        do_op(1, 64'd1, 64'd0, 1'b0, 1, 64'd1, 1'b0, 1, "w1 1-0-0");
        do_op(1, 64'd1, 64'd1, 1'b1, 0, 64'd1, 1'b1, 1, "w1 1-1-1");
        do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0,
              64'd0, 1'b0, 64, "w64 max-max");
        do_op(2, 64'd0, 64'd1, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64, "w64 0-1");

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            do_op(0, 64'(ra), 64'(rb), rbin, int'($urandom_range(0, 3)),
                  64'(rexp[7:0]), rexp[8], 8, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
